// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer: holds the cipher state and feeds an
// external combinational round function, one round per clock.
module aes_round_ctrl #(
  parameter int NR        = 10,
  parameter int KEY_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [127:0]         data_in,
  input  logic [127:0]         round_key,
  output logic [KEY_IDX_W-1:0] key_idx,
  output logic [127:0]         round_state,
  input  logic [127:0]         round_result,
  output logic                 mix_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [127:0]         data_out,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam logic [KEY_IDX_W-1:0] LAST  = KEY_IDX_W'(NR);
  localparam logic [KEY_IDX_W-1:0] FIRST = KEY_IDX_W'(1);

  state_t                 st;
  logic [KEY_IDX_W-1:0]   cnt;
  logic [127:0]           state_q;
  logic                   idle_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      cnt       <= '0;
      state_q   <= '0;
      idle_q    <= 1'b1;
      key_idx   <= '0;
      mix_en    <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (in_valid) begin
            state_q <= data_in ^ round_key;
            cnt     <= FIRST;
            st      <= ROUND;
            idle_q  <= 1'b0;
            busy    <= 1'b1;
            key_idx <= FIRST;
            mix_en  <= (FIRST != LAST);
          end
        end
        ROUND: begin
          state_q <= round_result;
          if (cnt == LAST) begin
            st        <= DONE;
            key_idx   <= '0;
            mix_en    <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            cnt     <= cnt + FIRST;
            key_idx <= cnt + FIRST;
            mix_en  <= ((cnt + FIRST) != LAST);
          end
        end
        DONE: begin
          if (out_ready) begin
            st        <= IDLE;
            cnt       <= '0;
            idle_q    <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          st     <= IDLE;
          idle_q <= 1'b1;
        end
      endcase
    end
  end

  // in_ready depends only on registered state; rst gating keeps it low in reset
  assign in_ready    = idle_q & ~rst;
  assign round_state = state_q;
  assign data_out    = state_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl with a software AES round-function model.
module tb_aes_round_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  // NR=10 instance
  logic         in_valid = 0, in_ready, mix_en, out_valid, out_ready = 0, busy;
  logic [127:0] data_in = '0, round_key, round_state, round_result, data_out;
  logic [3:0]   key_idx;
  // NR=1 instance
  logic         in_valid1 = 0, in_ready1, mix_en1, out_valid1, out_ready1 = 0, busy1;
  logic [127:0] data_in1 = '0, round_key1, round_state1, round_result1, data_out1;
  logic [0:0]   key_idx1;
  logic [127:0] k1_0 = '0;

  aes_round_ctrl #(.NR(10), .KEY_IDX_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .round_key(round_key), .key_idx(key_idx), .round_state(round_state),
    .round_result(round_result), .mix_en(mix_en), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .busy(busy));

  aes_round_ctrl #(.NR(1), .KEY_IDX_W(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .data_in(data_in1),
    .round_key(round_key1), .key_idx(key_idx1), .round_state(round_state1),
    .round_result(round_result1), .mix_en(mix_en1), .out_valid(out_valid1),
    .out_ready(out_ready1), .data_out(data_out1), .busy(busy1));

  int total = 0, bad = 0, cyc = 0, hs_cyc = -100;
  logic mix1_seen = 1'b0;
  logic [127:0] q[$], q1[$];
  logic [127:0] rk [0:10];

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- AES model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p = 8'h01, t = a;
    for (int i = 1; i < 8; i++) begin
      t = gmul(t, t);
      p = gmul(p, t);
    end
    if (a == 8'h00) p = 8'h00;
    return p ^ rotl(p, 1) ^ rotl(p, 2) ^ rotl(p, 3) ^ rotl(p, 4) ^ 8'h63;
  endfunction
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic mix);
    logic [7:0] sb[16], sr[16], a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) sb[i] = sbox(s[8*i +: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c]; a1 = sr[4*c+1]; a2 = sr[4*c+2]; a3 = sr[4*c+3];
      if (mix) begin
        o[32*c +: 8]    = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        o[32*c+8 +: 8]  = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        o[32*c+16 +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        o[32*c+24 +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end else
        o[32*c +: 32] = {a3, a2, a1, a0};
    end
    return o ^ k;
  endfunction
  // FIPS hex literal (byte 0 leftmost) to bus order (byte 0 at [7:0])
  function automatic logic [127:0] fb(input logic [127:0] x);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[8*i +: 8] = x[8*(15-i) +: 8];
    return y;
  endfunction
  task automatic load_key(input logic [127:0] key);
    logic [31:0] w[44], t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[7:0], t[31:8]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {24'h0, rc};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
  endtask
  function automatic logic [127:0] model_encrypt(input logic [127:0] pt);
    logic [127:0] s = pt ^ rk[0];
    for (int r = 1; r <= 10; r++) s = aes_round(s, rk[r], r != 10);
    return s;
  endfunction

  assign round_key     = (key_idx <= 4'd10) ? rk[key_idx] : '0;
  assign round_result  = aes_round(round_state, round_key, mix_en);
  assign round_key1    = key_idx1[0] ? '0 : k1_0;
  assign round_result1 = round_state1;

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("sb0_unexpected_out", 1, 0);
      else chk("sb0_data_out", data_out, q.pop_front());
      hs_cyc = cyc;
    end
    if (!rst && out_valid1 && out_ready1) begin
      if (q1.size() == 0) chk("sb1_unexpected_out", 1, 0);
      else chk("sb1_data_out", data_out1, q1.pop_front());
    end
    if (mix_en1) mix1_seen = 1'b1;
  end

  task automatic accept(input logic [127:0] pt, input logic [127:0] exp);
    int g;
    @(posedge clk); #1;
    in_valid = 1; data_in = pt;
    for (g = 0; g < 40; g++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("accept_ready", {127'h0, g < 40}, 1);
    q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 0; data_in = {4{$urandom}};
  endtask

  task automatic track_rounds();
    int n = 0;
    for (int g = 0; g < 40; g++) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
      chk("key_idx", {124'h0, key_idx}, 128'(n));
      chk("mix_en", {127'h0, mix_en}, {127'h0, n != 10});
    end
    chk("latency", 128'(n), 10);
  endtask

  task automatic hold_and_drain(input logic [127:0] exp, input int hold);
    for (int h = 0; h < hold; h++) begin
      if (h > 0) @(negedge clk);
      chk("done_valid", {127'h0, out_valid}, 1);
      chk("done_data", data_out, exp);
      chk("done_in_ready", {127'h0, in_ready}, 0);
      chk("done_busy", {127'h0, busy}, 1);
    end
    @(posedge clk); #1 out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
    @(negedge clk);
    chk("post_valid", {127'h0, out_valid}, 0);
    chk("post_busy", {127'h0, busy}, 0);
    chk("post_in_ready", {127'h0, in_ready}, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] kc1, ptc1, ctc1, kb, ptb, ctb, e2;
    int acc_cyc, g, n;
    logic rdy_in_done;
    kc1  = fb(128'h000102030405060708090a0b0c0d0e0f);
    ptc1 = fb(128'h00112233445566778899aabbccddeeff);
    ctc1 = fb(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    kb   = fb(128'h2b7e151628aed2a6abf7158809cf4f3c);
    ptb  = fb(128'h3243f6a8885a308d313198a2e0370734);
    ctb  = fb(128'h3925841d02dc09fbdc118597196a0b32);
    load_key(kc1);

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {127'h0, in_ready}, 0);
    chk("rst_out_valid", {127'h0, out_valid}, 0);
    chk("rst_busy", {127'h0, busy}, 0);
    chk("rst_mix_en", {127'h0, mix_en}, 0);
    chk("rst_key_idx", {124'h0, key_idx}, 0);
    chk("rst_data_out", data_out, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("idle_in_ready", {127'h0, in_ready}, 1);

    // FIPS C.1, then a 20-cycle stall in DONE
    accept(ptc1, ctc1); track_rounds(); hold_and_drain(ctc1, 1);
    accept(ptc1, ctc1); track_rounds(); hold_and_drain(ctc1, 20);

    // back-to-back blocks with in_valid and out_ready held high
    e2 = model_encrypt(128'h0);
    @(posedge clk); #1;
    in_valid = 1; data_in = ptc1; out_ready = 1;
    q.push_back(ctc1);
    @(negedge clk);
    chk("b2b_first_ready", {127'h0, in_ready}, 1);
    @(posedge clk); #1 data_in = 128'h0;
    q.push_back(e2);
    acc_cyc = -1; rdy_in_done = 0;
    for (g = 0; g < 40; g++) begin
      @(negedge clk);
      if (out_valid && in_ready) rdy_in_done = 1;
      if (in_valid && in_ready) begin acc_cyc = cyc; break; end
    end
    chk("b2b_no_ready_in_done", {127'h0, rdy_in_done}, 0);
    chk("b2b_accept_after_hs", 128'(acc_cyc), 128'(hs_cyc + 1));
    @(posedge clk); #1 in_valid = 0;
    for (g = 0; g < 40 && q.size() != 0; g++) @(negedge clk);
    chk("b2b_drained", 128'(q.size()), 0);
    @(posedge clk); #1 out_ready = 0;

    // reset in the middle of ROUND
    accept(ptc1, ctc1);
    for (g = 0; g < 40; g++) begin
      @(negedge clk);
      if (key_idx == 4'd5) break;
    end
    chk("mid_cnt5_reached", {127'h0, key_idx == 4'd5}, 1);
    rst = 1; q.delete();
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("abort_valid", {127'h0, out_valid}, 0);
    chk("abort_data", data_out, 0);
    chk("abort_busy", {127'h0, busy}, 0);
    chk("abort_in_ready", {127'h0, in_ready}, 1);
    load_key(kb);
    accept(ptb, ctb); track_rounds(); hold_and_drain(ctb, 2);

    // NR=1 instance with identity round function
    for (int v = 0; v < 2; v++) begin
      @(posedge clk); #1;
      in_valid1 = 1;
      data_in1 = (v == 0) ? 128'h0 : {16{8'h5a}};
      k1_0     = (v == 0) ? 128'h0 : {16{8'h0f}};
      q1.push_back((v == 0) ? 128'h0 : {16{8'h55}});
      @(negedge clk);
      chk("nr1_in_ready", {127'h0, in_ready1}, 1);
      @(posedge clk); #1 in_valid1 = 0; k1_0 = '0;
      n = 0;
      for (g = 0; g < 20; g++) begin
        @(negedge clk);
        if (out_valid1) break;
        n++;
        chk("nr1_key_idx", {127'h0, key_idx1}, 1);
      end
      chk("nr1_latency", 128'(n), 1);
      @(posedge clk); #1 out_ready1 = 1;
      @(posedge clk); #1 out_ready1 = 0;
      @(negedge clk);
      chk("nr1_post_valid", {127'h0, out_valid1}, 0);
    end
    chk("nr1_mix_never", {127'h0, mix1_seen}, 0);
    chk("sb1_drained", 128'(q1.size()), 0);
    chk("sb0_drained", 128'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
